// File: rtl/fwd_defs.sv
// Shared definitions for the decode-stage forwarding/hazard controller:
// operand-mux select encoding and the in-flight writer slot record.
package fwd_defs;

  localparam int DEF_REG_ADDR_W = 3;
  // Slot rd field is sized for the widest supported register file; narrower
  // indices are zero-extended on entry so the record layout stays fixed.
  localparam int RD_MAX_W = 8;

  typedef enum logic [1:0] {
    SEL_RF  = 2'd0,
    SEL_EX  = 2'd1,
    SEL_MEM = 2'd2
  } fwd_sel_e;

  typedef struct packed {
    logic                valid;
    logic [RD_MAX_W-1:0] rd;
    logic                wr_en;
    logic                is_load;
  } slot_t;

  localparam int SLOT_W = $bits(slot_t);

endpackage

// File: rtl/fwd_operand_match.sv
// Per-operand forwarding match: compares one D-stage source against the EX and
// MEM writer slots and produces the mux select plus a load-use indication.
module fwd_operand_match
  import fwd_defs::*;
#(
  parameter int REG_ADDR_W   = DEF_REG_ADDR_W,
  parameter bit HAS_ZERO_REG = 1'b1
) (
  input  logic [REG_ADDR_W-1:0] i_rs,
  input  logic                  i_use,
  input  slot_t                 i_slot_ex,
  input  slot_t                 i_slot_mem,
  output logic [1:0]            o_sel,
  output logic                  o_load_hit
);

  logic [RD_MAX_W-1:0] w_rs_ext;
  logic                w_live;
  logic                w_ex_hit;
  logic                w_mem_hit;

  assign w_rs_ext = RD_MAX_W'(i_rs);

  // A hardwired-zero source never depends on an in-flight writer.
  assign w_live = i_use && !(HAS_ZERO_REG && (i_rs == '0));

  assign w_ex_hit  = w_live && i_slot_ex.valid && i_slot_ex.wr_en &&
                     (i_slot_ex.rd == w_rs_ext);
  assign w_mem_hit = w_live && i_slot_mem.valid && i_slot_mem.wr_en &&
                     (i_slot_mem.rd == w_rs_ext);

  always_comb begin
    o_sel = SEL_RF;
    if (w_ex_hit && !i_slot_ex.is_load) begin
      o_sel = SEL_EX;
    end else if (w_mem_hit) begin
      o_sel = SEL_MEM;
    end
  end

  assign o_load_hit = w_ex_hit && i_slot_ex.is_load;

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Decode-stage hazard and forwarding controller: tracks EX/MEM writers, drives
// operand-mux selects, inserts one-cycle load-use stalls and counts them.
module fwd_hazard_ctrl
  import fwd_defs::*;
#(
  parameter int REG_ADDR_W   = DEF_REG_ADDR_W,
  parameter bit HAS_ZERO_REG = 1'b1,
  parameter int CNT_W        = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  d_valid,
  input  logic [REG_ADDR_W-1:0] d_rs_a,
  input  logic [REG_ADDR_W-1:0] d_rs_b,
  input  logic                  d_use_a,
  input  logic                  d_use_b,
  input  logic [REG_ADDR_W-1:0] d_rd,
  input  logic                  d_wr_en,
  input  logic                  d_is_load,
  input  logic                  flush,
  output logic [1:0]            sel_a,
  output logic [1:0]            sel_b,
  output logic                  stall_d,
  output logic                  issue_valid,
  output logic [CNT_W-1:0]      stall_count
);

  slot_t            r_slot_ex;
  slot_t            r_slot_mem;
  slot_t            w_slot_issue;
  logic [CNT_W-1:0] r_stall_count;
  logic             w_load_hit_a;
  logic             w_load_hit_b;

  fwd_operand_match #(
    .REG_ADDR_W   (REG_ADDR_W),
    .HAS_ZERO_REG (HAS_ZERO_REG)
  ) u_match_a (
    .i_rs       (d_rs_a),
    .i_use      (d_use_a),
    .i_slot_ex  (r_slot_ex),
    .i_slot_mem (r_slot_mem),
    .o_sel      (sel_a),
    .o_load_hit (w_load_hit_a)
  );

  fwd_operand_match #(
    .REG_ADDR_W   (REG_ADDR_W),
    .HAS_ZERO_REG (HAS_ZERO_REG)
  ) u_match_b (
    .i_rs       (d_rs_b),
    .i_use      (d_use_b),
    .i_slot_ex  (r_slot_ex),
    .i_slot_mem (r_slot_mem),
    .o_sel      (sel_b),
    .o_load_hit (w_load_hit_b)
  );

  // Gated by rst_n so nothing is stalled or issued while the pipe is held in reset.
  assign stall_d     = rst_n && d_valid && !flush && (w_load_hit_a || w_load_hit_b);
  assign issue_valid = rst_n && d_valid && !stall_d && !flush;

  always_comb begin
    w_slot_issue = '0;
    if (issue_valid) begin
      w_slot_issue.valid   = 1'b1;
      w_slot_issue.rd      = RD_MAX_W'(d_rd);
      w_slot_issue.wr_en   = d_wr_en;
      w_slot_issue.is_load = d_is_load;
    end
  end

  // NOTE: state updates use non-blocking assignments so slot_mem samples the
  // pre-edge slot_ex rather than the value being written in the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_slot_ex     <= '0;
      r_slot_mem    <= '0;
      r_stall_count <= '0;
    end else begin
      r_slot_mem <= flush ? slot_t'('0) : r_slot_ex;
      r_slot_ex  <= w_slot_issue;
      if (stall_d && (r_stall_count != {CNT_W{1'b1}})) begin
        r_stall_count <= r_stall_count + 1'b1;
      end
    end
  end

  assign stall_count = r_stall_count;

endmodule
